// File: rtl/eth_pkt_chk_pkg.sv
// Shared types and default limits for the egress packet checker.
//   state_e    : framing FSM states
//   err_code_e : error code reported alongside outErr on the closing word
package eth_pkt_chk_pkg;

  typedef enum logic {IDLE, IN_PKT} state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_ABORT    = 2'd1,
    ERR_RUNT     = 2'd2,
    ERR_OVERSIZE = 2'd3
  } err_code_e;

  localparam int DEF_MIN_WORDS = 1;
  localparam int DEF_MAX_WORDS = 190;   // 1518 B / 8 B per word

endpackage

// File: rtl/eth_sat_cnt.sv
// Saturating statistics counter.
//   clk, resetN : clock, async active-low reset
//   inc         : add 1 this cycle
//   inc2        : add 2 this cycle (takes precedence over inc)
//   cnt         : count, sticks at all-ones instead of wrapping
module eth_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inc,
  input  logic             inc2,
  output logic [CNT_W-1:0] cnt
);

  // One extra bit catches the carry out so saturation is a single test.
  logic [CNT_W:0] sum;

  always_comb begin
    sum = {1'b0, cnt};
    if (inc2)     sum = sum + (CNT_W+1)'(2);
    else if (inc) sum = sum + (CNT_W+1)'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)          cnt <= '0;
    else if (sum[CNT_W])  cnt <= '1;
    else                  cnt <= sum[CNT_W-1:0];
  end

endmodule

// File: rtl/eth_pkt_checker.sv
// Egress framing checker downstream of eth_sw. Forwards the word stream with
// one register of latency, checks Sop/Eop framing and packet length, flags bad
// packets on their closing word and keeps saturating statistics.
//   clk, resetN                     : clock, async active-low reset
//   inData/inSop/inEop/inVld        : input word stream (flags qualified by inVld)
//   outData/outSop/outEop/outVld    : registered copy of the stream
//   outErr, errCode                 : bad-packet flag and reason (0 when outErr=0)
//   pktCnt, errCnt                  : good / bad packet counts, saturating
//   lastLen                         : word count of the most recently closed packet
// Optional: define ETH_PKT_CHK_XSUM_EN to add outXsum, the XOR of all data
// words of the packet, presented with outEop and held until the next outEop.
module eth_pkt_checker
  import eth_pkt_chk_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MIN_WORDS = DEF_MIN_WORDS,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int CNT_W     = 32,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [DATA_W-1:0] inData,
  input  logic              inSop,
  input  logic              inEop,
  input  logic              inVld,
  output logic [DATA_W-1:0] outData,
  output logic              outSop,
  output logic              outEop,
  output logic              outVld,
  output logic              outErr,
  output logic [1:0]        errCode,
  output logic [CNT_W-1:0]  pktCnt,
  output logic [CNT_W-1:0]  errCnt,
  output logic [LEN_W-1:0]  lastLen
`ifdef ETH_PKT_CHK_XSUM_EN
  ,
  output logic [DATA_W-1:0] outXsum
`endif
);

  function automatic err_code_e classify(input logic [LEN_W-1:0] len);
    if (int'(len) < MIN_WORDS)      return ERR_RUNT;
    else if (int'(len) > MAX_WORDS) return ERR_OVERSIZE;
    else                            return ERR_OK;
  endfunction

  state_e           state, stNext;
  logic [LEN_W-1:0] wordCnt, cntNext, lenInc, lenVal;
  err_code_e        codeNext, singleCode, closeCode;
  logic             errNext, lenLoad, pktInc, errInc, errInc2;

  assign lenInc     = (&wordCnt) ? wordCnt : wordCnt + LEN_W'(1);
  assign singleCode = classify(LEN_W'(1));
  assign closeCode  = classify(lenInc);

  always_comb begin
    stNext   = state;
    cntNext  = wordCnt;
    errNext  = 1'b0;
    codeNext = ERR_OK;
    lenLoad  = 1'b0;
    lenVal   = '0;
    pktInc   = 1'b0;
    errInc   = 1'b0;
    errInc2  = 1'b0;
    if (inVld) begin
      if (state == IN_PKT && inSop) begin
        // Missing Eop: close the old packet as ABORT on the new Sop word.
        errNext  = 1'b1;
        codeNext = ERR_ABORT;
        lenLoad  = 1'b1;
        lenVal   = wordCnt;
        cntNext  = LEN_W'(1);
        if (inEop) begin
          // New single-word packet closes too; its own error wins the code.
          lenVal = LEN_W'(1);
          stNext = IDLE;
          if (singleCode != ERR_OK) begin
            codeNext = singleCode;
            errInc2  = 1'b1;
          end else begin
            errInc = 1'b1;
            pktInc = 1'b1;
          end
        end else begin
          errInc = 1'b1;
        end
      end else if (state == IN_PKT) begin
        cntNext = lenInc;
        if (inEop) begin
          lenLoad = 1'b1;
          lenVal  = lenInc;
          stNext  = IDLE;
          if (closeCode != ERR_OK) begin
            errNext  = 1'b1;
            codeNext = closeCode;
            errInc   = 1'b1;
          end else begin
            pktInc = 1'b1;
          end
        end
      end else if (inSop) begin
        cntNext = LEN_W'(1);
        if (inEop) begin
          lenLoad = 1'b1;
          lenVal  = LEN_W'(1);
          if (singleCode != ERR_OK) begin
            errNext  = 1'b1;
            codeNext = singleCode;
            errInc   = 1'b1;
          end else begin
            pktInc = 1'b1;
          end
        end else begin
          stNext = IN_PKT;
        end
      end else if (inEop) begin
        // Orphan Eop outside any packet.
        errNext  = 1'b1;
        codeNext = ERR_ABORT;
        errInc   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      wordCnt <= '0;
      outData <= '0;
      outSop  <= 1'b0;
      outEop  <= 1'b0;
      outVld  <= 1'b0;
      outErr  <= 1'b0;
      errCode <= 2'd0;
      lastLen <= '0;
    end else begin
      state   <= stNext;
      wordCnt <= cntNext;
      outData <= inData;
      outSop  <= inSop & inVld;
      outEop  <= inEop & inVld;
      outVld  <= inVld;
      outErr  <= errNext;
      errCode <= codeNext;
      if (lenLoad) lastLen <= lenVal;
    end
  end

  eth_sat_cnt #(.CNT_W(CNT_W)) uPktCnt (
    .clk(clk), .resetN(resetN), .inc(pktInc), .inc2(1'b0), .cnt(pktCnt)
  );

  eth_sat_cnt #(.CNT_W(CNT_W)) uErrCnt (
    .clk(clk), .resetN(resetN), .inc(errInc), .inc2(errInc2), .cnt(errCnt)
  );

`ifdef ETH_PKT_CHK_XSUM_EN
  logic [DATA_W-1:0] xAcc, xNext;

  // Sop (or any word seen outside a packet) restarts the running XOR.
  assign xNext = (inSop || state == IDLE) ? inData : (xAcc ^ inData);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      xAcc    <= '0;
      outXsum <= '0;
    end else if (inVld) begin
      xAcc <= xNext;
      if (inEop) outXsum <= xNext;
    end
  end
`endif

endmodule

// File: tb/tb_eth_pkt_checker.sv
module tb_eth_pkt_checker;

  localparam int DW = 64;
  localparam int LW = 16;
  localparam int MINW [2] = '{1, 8};
  localparam int MAXW [2] = '{190, 190};
  localparam longint CMAX [2] = '{64'hFFFF_FFFF, 64'd7};

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic [DW-1:0] inData = '0;
  logic          inSop = 1'b0, inEop = 1'b0, inVld = 1'b0;

  logic [DW-1:0] oData [2];
  logic          oSop [2], oEop [2], oVld [2], oErr [2];
  logic [1:0]    oCode [2];
  logic [LW-1:0] lastL [2];
  logic [31:0]   pktA, errA;
  logic [2:0]    pktB, errB;
`ifdef ETH_PKT_CHK_XSUM_EN
  logic [DW-1:0] xsum [2];
`endif

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  // Instance 0: default limits. Instance 1: MIN_WORDS=8 and 3-bit counters
  // so saturation is reachable.
  eth_pkt_checker dutA (
    .clk(clk), .resetN(resetN), .inData(inData), .inSop(inSop), .inEop(inEop), .inVld(inVld),
    .outData(oData[0]), .outSop(oSop[0]), .outEop(oEop[0]), .outVld(oVld[0]),
    .outErr(oErr[0]), .errCode(oCode[0]), .pktCnt(pktA), .errCnt(errA), .lastLen(lastL[0])
`ifdef ETH_PKT_CHK_XSUM_EN
    , .outXsum(xsum[0])
`endif
  );

  eth_pkt_checker #(.MIN_WORDS(8), .CNT_W(3)) dutB (
    .clk(clk), .resetN(resetN), .inData(inData), .inSop(inSop), .inEop(inEop), .inVld(inVld),
    .outData(oData[1]), .outSop(oSop[1]), .outEop(oEop[1]), .outVld(oVld[1]),
    .outErr(oErr[1]), .errCode(oCode[1]), .pktCnt(pktB), .errCnt(errB), .lastLen(lastL[1])
`ifdef ETH_PKT_CHK_XSUM_EN
    , .outXsum(xsum[1])
`endif
  );

  // ---------------- reference model (packet level) ----------------
  bit            mInPkt;
  int            mLen;
  logic [DW-1:0] xq [$];
  logic [DW-1:0] mX;
  bit            xKnown;
  bit            eVld, eSop, eEop;
  logic [DW-1:0] eData;
  bit            mErrF [2];
  int            mCode [2];
  longint        mPkt [2], mErr [2];
  int            mLast [2];

  function automatic int classify(int n, int d);
    if (n < MINW[d]) return 2;
    if (n > MAXW[d]) return 3;
    return 0;
  endfunction

  function automatic longint sat1(longint v, int d);
    return (v >= CMAX[d]) ? CMAX[d] : v + 1;
  endfunction

  function automatic logic [DW-1:0] xorAll();
    logic [DW-1:0] r = '0;
    foreach (xq[i]) r ^= xq[i];
    return r;
  endfunction

  task automatic modelClear();
    mInPkt = 0; mLen = 0; xq.delete(); mX = '0; xKnown = 1;
    eVld = 0; eSop = 0; eEop = 0; eData = '0;
    for (int d = 0; d < 2; d++) begin
      mErrF[d] = 0; mCode[d] = 0; mPkt[d] = 0; mErr[d] = 0; mLast[d] = 0;
    end
  endtask

  task automatic modelCycle(bit v, bit s, bit e, logic [DW-1:0] dat);
    int c, n;
    eVld = v; eSop = v && s; eEop = v && e; eData = dat;
    for (int d = 0; d < 2; d++) begin
      mErrF[d] = 0; mCode[d] = 0;
      if (!v) continue;
      if (mInPkt && s) begin
        mErrF[d] = 1; mCode[d] = 1; mErr[d] = sat1(mErr[d], d); mLast[d] = mLen;
        if (e) begin
          c = classify(1, d); mLast[d] = 1;
          if (c != 0) begin mCode[d] = c; mErr[d] = sat1(mErr[d], d); end
          else mPkt[d] = sat1(mPkt[d], d);
        end
      end else if ((mInPkt && e) || (!mInPkt && s && e)) begin
        n = mInPkt ? ((mLen + 1 > 65535) ? 65535 : mLen + 1) : 1;
        c = classify(n, d); mLast[d] = n;
        if (c != 0) begin mErrF[d] = 1; mCode[d] = c; mErr[d] = sat1(mErr[d], d); end
        else mPkt[d] = sat1(mPkt[d], d);
      end else if (!mInPkt && e) begin
        mErrF[d] = 1; mCode[d] = 1; mErr[d] = sat1(mErr[d], d);
      end
    end
    if (v) begin
      if (s) xq = '{dat};
      else if (mInPkt) xq.push_back(dat);
      if (e) begin
        if (s || mInPkt) begin mX = xorAll(); xKnown = 1; end
        else xKnown = 0;
      end
      if (s && !e)      begin mInPkt = 1; mLen = 1; end
      else if (e)       mInPkt = 0;
      else if (mInPkt)  mLen = (mLen >= 65535) ? 65535 : mLen + 1;
    end
  endtask

  // Drive one cycle, let the edge happen, sample 1 time unit later.
  task automatic step(bit v, bit s, bit e, logic [DW-1:0] dat);
    inVld = v; inSop = s; inEop = e; inData = dat;
    @(posedge clk); #1;
    modelCycle(v, s, e, dat);
  endtask

  task automatic doReset();
    inVld = 0; inSop = 0; inEop = 0; inData = '0;
    resetN = 0;
    repeat (2) @(posedge clk);
    #1 resetN = 1;
    modelClear();
  endtask

  task automatic sendPkt(int len, bit withEop);
    for (int w = 0; w < len; w++)
      step(1, w == 0, withEop && (w == len - 1), {$urandom, $urandom});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetN = 0; #2;
    nTests++;
    if ({oSop[0], oEop[0], oVld[0], oErr[0], oCode[0]} !== 6'b0 || oData[0] !== '0 ||
        pktA !== 0 || errA !== 0 || lastL[0] !== 0) begin
      nFail++; $display("FAIL reset_outputs: got vld=%0b err=%0b pkt=%0d err=%0d len=%0d exp all 0",
                        oVld[0], oErr[0], pktA, errA, lastL[0]);
    end
    doReset();
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 8; w++) begin
        step(1, w == 0, w == 7, {$urandom, $urandom});
        if (w == 7) begin
          nTests++;
          if (oEop[0] !== 1'b1 || oErr[0] !== 1'b0) begin
            nFail++; $display("FAIL b2b_eop pkt%0d: got eop=%0b err=%0b exp eop=1 err=0", p, oEop[0], oErr[0]);
          end
        end
      end
    end
    nTests++;
    if (pktA !== 32'd3 || errA !== 32'd0 || lastL[0] !== 16'd8) begin
      nFail++; $display("FAIL b2b_stats: got pkt=%0d err=%0d len=%0d exp 3 0 8", pktA, errA, lastL[0]);
    end
  endtask

  task automatic test_abort();
    doReset();
    sendPkt(4, 1);
    sendPkt(3, 0);
    step(1, 1, 0, 64'hA5);
    nTests++;
    if (oSop[0] !== 1'b1 || oErr[0] !== 1'b1 || oCode[0] !== 2'd1 || oEop[0] !== 1'b0) begin
      nFail++; $display("FAIL abort_on_sop: got sop=%0b err=%0b code=%0d eop=%0b exp 1 1 1 0",
                        oSop[0], oErr[0], oCode[0], oEop[0]);
    end
    nTests++;
    if (lastL[0] !== 16'd3) begin
      nFail++; $display("FAIL abort_len: got %0d exp 3", lastL[0]);
    end
    step(1, 0, 1, 64'h5A);
    nTests++;
    if (errA !== 32'd1 || pktA !== 32'd2 || lastL[0] !== 16'd2 || oErr[0] !== 1'b0 || oCode[0] !== 2'd0) begin
      nFail++; $display("FAIL abort_stats: got err=%0d pkt=%0d len=%0d oerr=%0b code=%0d exp 1 2 2 0 0",
                        errA, pktA, lastL[0], oErr[0], oCode[0]);
    end
  endtask

  task automatic test_oversize();
    doReset();
    sendPkt(191, 1);
    nTests++;
    if (oErr[0] !== 1'b1 || oCode[0] !== 2'd3 || lastL[0] !== 16'd191 || errA !== 32'd1 || pktA !== 32'd0) begin
      nFail++; $display("FAIL oversize: got err=%0b code=%0d len=%0d errCnt=%0d pkt=%0d exp 1 3 191 1 0",
                        oErr[0], oCode[0], lastL[0], errA, pktA);
    end
    sendPkt(190, 1);
    nTests++;
    if (oErr[0] !== 1'b0 || pktA !== 32'd1 || lastL[0] !== 16'd190) begin
      nFail++; $display("FAIL max_legal: got err=%0b pkt=%0d len=%0d exp 0 1 190", oErr[0], pktA, lastL[0]);
    end
  endtask

  task automatic test_runt_orphan();
    doReset();
    step(1, 1, 1, 64'h11);
    nTests++;
    if (oErr[1] !== 1'b1 || oCode[1] !== 2'd2 || lastL[1] !== 16'd1) begin
      nFail++; $display("FAIL runt: got err=%0b code=%0d len=%0d exp 1 2 1", oErr[1], oCode[1], lastL[1]);
    end
    step(1, 0, 1, 64'h22);
    nTests++;
    if (oEop[1] !== 1'b1 || oErr[1] !== 1'b1 || oCode[1] !== 2'd1 || errB !== 3'd2) begin
      nFail++; $display("FAIL orphan: got eop=%0b err=%0b code=%0d errCnt=%0d exp 1 1 1 2",
                        oEop[1], oErr[1], oCode[1], errB);
    end
    // Abort plus a bad single-word packet in the same cycle.
    sendPkt(2, 0);
    step(1, 1, 1, 64'h33);
    nTests++;
    if (oCode[1] !== 2'd2 || errB !== 3'd4 || lastL[1] !== 16'd1 || oCode[0] !== 2'd1 || errA !== 32'd2) begin
      nFail++; $display("FAIL abort_runt: got codeB=%0d errB=%0d lenB=%0d codeA=%0d errA=%0d exp 2 4 1 1 2",
                        oCode[1], errB, lastL[1], oCode[0], errA);
    end
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 0; i < 10; i++) step(1, 0, 1, 64'h0);
    nTests++;
    if (errB !== 3'd7 || errA !== 32'd10) begin
      nFail++; $display("FAIL saturate: got errB=%0d errA=%0d exp 7 10", errB, errA);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    sendPkt(5, 0);
    resetN = 0; #1;
    nTests++;
    if ({oSop[0], oEop[0], oVld[0], oErr[0], oCode[0]} !== 6'b0 || oData[0] !== '0 ||
        pktA !== 0 || errA !== 0 || lastL[0] !== 0) begin
      nFail++; $display("FAIL reset_mid_outputs: got vld=%0b data=%0h len=%0d exp 0", oVld[0], oData[0], lastL[0]);
    end
    repeat (2) @(posedge clk);
    #1 resetN = 1;
    modelClear();
    sendPkt(8, 1);
    nTests++;
    if (pktA !== 32'd1 || lastL[0] !== 16'd8 || errA !== 32'd0) begin
      nFail++; $display("FAIL reset_mid_after: got pkt=%0d len=%0d err=%0d exp 1 8 0", pktA, lastL[0], errA);
    end
  endtask

`ifdef ETH_PKT_CHK_XSUM_EN
  task automatic test_xsum();
    doReset();
    step(1, 1, 0, 64'h1);
    step(0, 1, 1, 64'hFF00);
    nTests++;
    if (oVld[0] !== 1'b0 || oEop[0] !== 1'b0 || oSop[0] !== 1'b0) begin
      nFail++; $display("FAIL xsum_gap: got vld=%0b eop=%0b sop=%0b exp 0", oVld[0], oEop[0], oSop[0]);
    end
    step(1, 0, 0, 64'h2);
    step(0, 0, 1, 64'hF0);
    step(1, 0, 1, 64'h4);
    nTests++;
    if (oEop[0] !== 1'b1 || xsum[0] !== 64'h7 || oErr[0] !== 1'b0 || lastL[0] !== 16'd3) begin
      nFail++; $display("FAIL xsum: got eop=%0b xsum=%0h err=%0b len=%0d exp 1 7 0 3",
                        oEop[0], xsum[0], oErr[0], lastL[0]);
    end
    step(1, 0, 0, 64'h9);
    nTests++;
    if (xsum[0] !== 64'h7) begin
      nFail++; $display("FAIL xsum_hold: got %0h exp 7", xsum[0]);
    end
  endtask
`endif

  typedef struct packed { bit v; bit s; bit e; } stim_t;

  task automatic test_random();
    stim_t q [$];
    stim_t st;
    logic [DW-1:0] dat;
    doReset();
    for (int it = 0; it < 300; it++) begin
      int kind = $urandom_range(0, 19);
      int len  = (kind == 0) ? $urandom_range(186, 194) : $urandom_range(1, 12);
      for (int w = 0; w < len; w++) begin
        st.v = 1; st.s = (w == 0); st.e = (w == len - 1);
        if (kind == 1 && w == len - 1) st.e = 0;   // missing Eop
        if (kind == 2 && w == 0)       st.s = 0;   // stray data / orphan Eop
        while ($urandom_range(0, 4) == 0) begin
          stim_t g;
          g.v = 0; g.s = 1'($urandom); g.e = 1'($urandom);
          q.push_back(g);
        end
        q.push_back(st);
      end
    end
    foreach (q[i]) begin
      dat = {$urandom, $urandom};
      step(q[i].v, q[i].s, q[i].e, dat);
      for (int d = 0; d < 2; d++) begin
        nTests++;
        if ({oVld[d], oSop[d], oEop[d]} !== {eVld, eSop, eEop} || oData[d] !== eData) begin
          nFail++; $display("FAIL rnd_stream c%0d d%0d: got %b %0h exp %b %0h", i, d,
                            {oVld[d], oSop[d], oEop[d]}, oData[d], {eVld, eSop, eEop}, eData);
        end
        nTests++;
        if (oErr[d] !== mErrF[d] || oCode[d] !== 2'(mCode[d])) begin
          nFail++; $display("FAIL rnd_err c%0d d%0d: got err=%0b code=%0d exp err=%0b code=%0d",
                            i, d, oErr[d], oCode[d], mErrF[d], mCode[d]);
        end
        nTests++;
        if (lastL[d] !== LW'(mLast[d])) begin
          nFail++; $display("FAIL rnd_len c%0d d%0d: got %0d exp %0d", i, d, lastL[d], mLast[d]);
        end
`ifdef ETH_PKT_CHK_XSUM_EN
        if (xKnown) begin
          nTests++;
          if (xsum[d] !== mX) begin
            nFail++; $display("FAIL rnd_xsum c%0d d%0d: got %0h exp %0h", i, d, xsum[d], mX);
          end
        end
`endif
      end
      nTests++;
      if (longint'(pktA) != mPkt[0] || longint'(errA) != mErr[0] ||
          longint'(pktB) != mPkt[1] || longint'(errB) != mErr[1]) begin
        nFail++; $display("FAIL rnd_cnt c%0d: got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", i,
                          pktA, errA, pktB, errB, mPkt[0], mErr[0], mPkt[1], mErr[1]);
      end
    end
  endtask

  initial begin
    modelClear();
    test_reset();
    test_back_to_back();
    test_abort();
    test_oversize();
    test_runt_orphan();
    test_saturation();
    test_reset_mid();
`ifdef ETH_PKT_CHK_XSUM_EN
    test_xsum();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
